// File: rtl/risc_prog_loader.sv
// Byte-stream program loader for the 8-bit RISC core: parses SYNC/ADDR/LEN/data/CSUM
// frames, writes the payload into core memory and releases the core on a good checksum.
module risc_prog_loader #(
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       mem_we,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic       core_run,
  output logic       done,
  output logic       err
);

  typedef enum logic [2:0] {
    S_SYNC = 3'd0,
    S_ADDR = 3'd1,
    S_LEN  = 3'd2,
    S_DATA = 3'd3,
    S_CSUM = 3'd4,
    S_RUN  = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  ptr_q, ptr_d;
  logic [7:0]  sum_q, sum_d;
  logic [8:0]  cnt_q, cnt_d;
  logic [15:0] tmo_q, tmo_d;
  logic        we_q, we_d;
  logic [7:0]  addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        run_q, run_d;
  logic        hs;
  logic        tmo_active;
  logic [7:0]  sum_next;

  assign in_ready   = (state_q != S_RUN);
  assign hs         = in_valid & in_ready;
  assign sum_next   = sum_q + in_data;
  assign tmo_active = (TIMEOUT != 0) &&
                      (state_q == S_ADDR || state_q == S_LEN ||
                       state_q == S_DATA || state_q == S_CSUM);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    run_d   = run_q;
    if (hs) begin
      tmo_d = 16'd0;
      case (state_q)
        S_SYNC: if (in_data == SYNC_BYTE) state_d = S_ADDR;
        S_ADDR: begin
          ptr_d   = in_data;
          sum_d   = in_data;
          state_d = S_LEN;
        end
        S_LEN: begin
          cnt_d   = (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
          sum_d   = sum_next;
          state_d = S_DATA;
        end
        S_DATA: begin
          we_d    = 1'b1;
          addr_d  = ptr_q;
          wdata_d = in_data;
          ptr_d   = ptr_q + 8'd1;
          sum_d   = sum_next;
          cnt_d   = cnt_q - 9'd1;
          if (cnt_q == 9'd1) state_d = S_CSUM;
        end
        S_CSUM: begin
          sum_d = sum_next;
          if (sum_next == 8'd0) begin
            done_d  = 1'b1;
            run_d   = 1'b1;
            state_d = S_RUN;
          end else begin
            err_d   = 1'b1;
            state_d = S_SYNC;
          end
        end
        default: state_d = state_q;
      endcase
    end else if (tmo_active) begin
      // Terminal count reached after TIMEOUT consecutive idle cycles.
      if (tmo_q == 16'(TIMEOUT - 1)) begin
        err_d   = 1'b1;
        tmo_d   = 16'd0;
        state_d = S_SYNC;
      end else begin
        tmo_d = tmo_q + 16'd1;
      end
    end else begin
      tmo_d = 16'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_SYNC;
      ptr_q   <= 8'd0;
      sum_q   <= 8'd0;
      cnt_q   <= 9'd0;
      tmo_q   <= 16'd0;
      we_q    <= 1'b0;
      addr_q  <= 8'd0;
      wdata_q <= 8'd0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
      run_q   <= run_d;
    end
  end

  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign done      = done_q;
  assign err       = err_q;
  assign core_run  = run_q;

endmodule

// File: tb/tb_risc_prog_loader.sv
// Directed bench for risc_prog_loader: frames, checksum errors, wrap, full length,
// timeout, mid-frame reset and throttled input, checked against hand-computed values.
module tb_risc_prog_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready, mem_we, core_run, done, err;
  logic [7:0] mem_addr, mem_wdata;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0, err_cnt = 0, both_cnt = 0;
  logic [7:0] m [256];
  logic [7:0] wa [$];
  logic [7:0] wd [$];
  int         wc [$];

  risc_prog_loader #(.SYNC_BYTE(8'hA5), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .core_run(core_run), .done(done), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mem_we) begin
      m[mem_addr] = mem_wdata;
      wa.push_back(mem_addr);
      wd.push_back(mem_wdata);
      wc.push_back(cyc);
    end
    if (done) done_cnt++;
    if (err) err_cnt++;
    if (done && err) both_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    wa.delete(); wd.delete(); wc.delete();
    done_cnt = 0; err_cnt = 0; both_cnt = 0;
    for (int i = 0; i < 256; i++) m[i] = 8'h00;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk);
    #1;
  endtask

  task automatic send_q(input logic [7:0] q [$], input bit throttle);
    foreach (q[i]) begin
      if (throttle) idle(1);
      send(q[i]);
    end
    in_valid = 1'b0;
  endtask

  logic [7:0] good [$];
  logic [7:0] bad  [$];
  int         nbad;

  initial begin
    good = '{8'hA5, 8'h10, 8'h03, 8'h11, 8'h22, 8'h33, 8'h87};
    bad  = '{8'hA5, 8'h10, 8'h03, 8'h11, 8'h22, 8'h33, 8'h88};

    // Reset state
    #2;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_core_run", core_run, 0);
    do_reset();

    // Good frame, in_valid held high
    send_q(good, 0);
    idle(3);
    chk("good_wcount", wa.size(), 3);
    chk("good_a0", wa[0], 8'h10); chk("good_d0", wd[0], 8'h11);
    chk("good_a1", wa[1], 8'h11); chk("good_d1", wd[1], 8'h22);
    chk("good_a2", wa[2], 8'h12); chk("good_d2", wd[2], 8'h33);
    chk("good_b2b_1", wc[1] - wc[0], 1);
    chk("good_b2b_2", wc[2] - wc[1], 1);
    chk("good_done", done_cnt, 1);
    chk("good_err", err_cnt, 0);
    chk("good_run", core_run, 1);
    chk("good_ready", in_ready, 0);
    in_valid = 1'b1; in_data = 8'hA5;
    repeat (5) @(posedge clk);
    #1 in_valid = 1'b0;
    idle(2);
    chk("run_ignores_wcount", wa.size(), 3);
    chk("run_sticky", core_run, 1);

    // Bad checksum then good frame
    do_reset();
    send_q(bad, 0);
    idle(3);
    chk("bad_wcount", wa.size(), 3);
    chk("bad_err", err_cnt, 1);
    chk("bad_done", done_cnt, 0);
    chk("bad_run", core_run, 0);
    chk("bad_ready", in_ready, 1);
    send_q(good, 0);
    idle(3);
    chk("rec_wcount", wa.size(), 6);
    chk("rec_done", done_cnt, 1);
    chk("rec_run", core_run, 1);
    chk("rec_m12", m[8'h12], 8'h33);

    // Leading garbage and address wrap
    do_reset();
    send_q('{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'hFE, 8'h03, 8'h01, 8'h02, 8'h03, 8'hF9}, 0);
    idle(3);
    chk("wrap_wcount", wa.size(), 3);
    chk("wrap_a0", wa[0], 8'hFE); chk("wrap_d0", wd[0], 8'h01);
    chk("wrap_a1", wa[1], 8'hFF); chk("wrap_d1", wd[1], 8'h02);
    chk("wrap_a2", wa[2], 8'h00); chk("wrap_d2", wd[2], 8'h03);
    chk("wrap_done", done_cnt, 1);

    // Full-length frame (LEN=0 -> 256 bytes)
    do_reset();
    send(8'hA5); send(8'h00); send(8'h00);
    for (int i = 0; i < 256; i++) send(8'(i));
    send(8'h80);
    idle(3);
    chk("full_wcount", wa.size(), 256);
    nbad = 0;
    for (int i = 0; i < 256; i++) if (m[i] !== 8'(i)) nbad++;
    chk("full_mem_bad", nbad, 0);
    chk("full_last_addr", wa[255], 8'hFF);
    chk("full_done", done_cnt, 1);
    chk("full_run", core_run, 1);

    // Timeout after 8 idle cycles inside a frame
    do_reset();
    send(8'hA5); send(8'h20);
    idle(7);
    chk("tmo_7_err", err_cnt, 0);
    chk("tmo_7_ready", in_ready, 1);
    idle(1);
    chk("tmo_8_err", err, 1);
    idle(1);
    chk("tmo_err_pulse", err, 0);
    chk("tmo_err_cnt", err_cnt, 1);
    send_q('{8'hA5, 8'h30, 8'h02, 8'hAA, 8'hBB, 8'h69}, 0);
    idle(3);
    chk("tmo_next_done", done_cnt, 1);
    chk("tmo_next_m30", m[8'h30], 8'hAA);
    chk("tmo_next_m31", m[8'h31], 8'hBB);

    // Reset mid-frame, after the second data byte
    do_reset();
    send_q('{8'hA5, 8'h10, 8'h03, 8'h11, 8'h22}, 0);
    rst = 1'b1;
    #1;
    chk("mrst_we", mem_we, 0);
    chk("mrst_addr", mem_addr, 0);
    chk("mrst_wdata", mem_wdata, 0);
    chk("mrst_ready", in_ready, 1);
    chk("mrst_run", core_run, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("mrst_wcount", wa.size(), 1);
    send_q(good, 0);
    idle(3);
    chk("mrst_after_done", done_cnt, 1);
    chk("mrst_after_m11", m[8'h11], 8'h22);
    chk("mrst_after_wcount", wa.size(), 4);

    // Throttled input
    do_reset();
    send_q(good, 1);
    idle(3);
    chk("thr_wcount", wa.size(), 3);
    chk("thr_a2", wa[2], 8'h12); chk("thr_d2", wd[2], 8'h33);
    chk("thr_gap", wc[1] - wc[0], 2);
    chk("thr_done", done_cnt, 1);
    chk("thr_run", core_run, 1);
    chk("never_done_and_err", both_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/risc_prog_loader.md
Name: risc_prog_loader

Overview:
- Upstream stage of the 8-bit RISC core.
- Receives a framed program image as a byte stream over a valid/ready handshake and writes it into the core's 256x8 memory through a write port.
- On a frame with a good checksum, asserts core_run so the core starts fetching at PC=0.
- Lets the team load test programs (multiply, Fibonacci) from a bench or host link instead of hardcoded initial blocks.

Parameters:
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT, 255, max idle cycles between accepted bytes inside a frame; 0 disables the timeout.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  in_data holds a byte.
- in_data  in  8  stream byte.
- in_ready  out  1  loader can accept a byte; a byte transfers when in_valid & in_ready at posedge.
- mem_we  out  1  write strobe to core memory.
- mem_addr  out  8  write address.
- mem_wdata  out  8  write data.
- core_run  out  1  core enable/release; sticky until rst.
- done  out  1  one-cycle pulse on accepting a good frame.
- err  out  1  one-cycle pulse on bad checksum or timeout.

Behaviour:
- Frame format: SYNC_BYTE, ADDR, LEN, LEN data bytes, CSUM.
  - LEN=0 means 256 data bytes.
  - The frame is good iff (ADDR + LEN + all data + CSUM) mod 256 == 8'h00.
- Reset (async, takes effect immediately, including mid-frame):
  - state=SYNC; in_ready=1; mem_we=0; mem_addr=0; mem_wdata=0; core_run=0; done=0; err=0.
  - Checksum, byte counter and timeout counter cleared.
- States:
  - SYNC: accepted byte == SYNC_BYTE -> ADDR. Any other byte is dropped; stay in SYNC.
  - ADDR: accepted byte loads the address pointer and seeds the checksum -> LEN.
  - LEN: accepted byte loads the remaining count (0 -> 256) and adds to the checksum -> DATA.
  - DATA: each accepted byte is written to the pointer, added to the checksum, increments the pointer, and decrements the count. The last byte -> CSUM.
  - CSUM: accepted byte is added to the checksum.
    - Sum == 0: done=1 for one cycle, core_run=1, -> RUN.
    - Otherwise: err=1 for one cycle, -> SYNC.
  - RUN: in_ready=0; all input is ignored. Only rst leaves RUN.
- in_ready is 1 in SYNC, ADDR, LEN, DATA and CSUM, and 0 in RUN. It is never dependent on in_valid in the same cycle.
- Write timing:
  - Registered: mem_we=1 with mem_addr/mem_wdata valid in the cycle after the data byte handshake, for exactly one cycle per byte.
  - Back-to-back bytes produce back-to-back writes.
- Pointer wraps mod 256: 8'hFF + 1 -> 8'h00. No overflow flag.
- Writes are not rolled back on a bad checksum. Memory may hold partial data; core_run stays 0.
- Timeout:
  - In ADDR, LEN, DATA or CSUM, a counter increments each cycle with no handshake and resets on each handshake.
  - On reaching TIMEOUT: err pulse, -> SYNC.
  - Inactive in SYNC and RUN.
- A SYNC_BYTE value arriving inside a frame is treated as ordinary payload (no resync).
- done and err are never asserted in the same cycle.
- core_run rises in the same cycle as done and stays high.

Test Plan:
- Good frame: send A5 10 03 11 22 33 87 with in_valid held high.
  - Required: mem writes (10,11), (11,22), (12,33) on consecutive cycles.
  - done pulse once; core_run=1; in_ready=0 afterward.
- Bad checksum: send A5 10 03 11 22 33 88.
  - Required: three writes, err pulse, core_run=0, in_ready=1.
  - Then send the good frame from the first scenario; it must complete normally.
- Leading garbage and address wrap: send 00 FF 5A, then A5 FE 03 01 02 03 F9.
  - Required: garbage ignored; writes to FE=01, FF=02, 00=03; done.
- Full-length frame: send A5 00 00, then 256 bytes of value i (sum 0x80), then CSUM 0x80.
  - Required: 256 writes, m[i]=i, done.
- Timeout with TIMEOUT=8: send A5 20, then hold in_valid low for 8 cycles.
  - Required: err pulse, state back to SYNC.
  - A subsequent full frame is accepted.
- Reset mid-frame: assert rst after the second data byte of the first scenario's frame.
  - Required: all outputs immediately at reset values, no further writes, core_run=0; a new frame then loads correctly.
- Throttled input: toggle in_valid every other cycle during a good frame.
  - Required: writes only follow handshakes; final result identical to the first scenario.
